// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: load/store size
// encodings and the access FSM state type.
package mem_access_stage_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int ADDR_WIDTH_DEFAULT = 14;

    // Load and store encodings overlap numerically; the opcode class picks the meaning.
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational byte-lane logic: store enables/replication, load select and
// extension, and the size/alignment legality check.
module load_store_align
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            we,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte = rdata[7:0];
        unique case (addr)
            2'd0: rbyte = rdata[7:0];
            2'd1: rbyte = rdata[15:8];
            2'd2: rbyte = rdata[23:16];
            2'd3: rbyte = rdata[31:24];
        endcase
        rhalf = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = '0;
        unique case (funct3)
            LB:      load_data = {{(DATA_WIDTH-8){rbyte[7]}}, rbyte};
            LH:      load_data = {{(DATA_WIDTH-16){rhalf[15]}}, rhalf};
            LW:      load_data = rdata;
            LBU:     load_data = {{(DATA_WIDTH-8){1'b0}}, rbyte};
            LHU:     load_data = {{(DATA_WIDTH-16){1'b0}}, rhalf};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        we    = 4'b0000;
        wdata = store_data;
        unique case (funct3)
            SB: begin
                we    = 4'b0001 << addr;
                wdata = {(DATA_WIDTH/8){store_data[7:0]}};
            end
            SH: begin
                we    = 4'b0011 << addr;
                wdata = {(DATA_WIDTH/16){store_data[15:0]}};
            end
            SW: begin
                we    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                we    = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    // Encodings 011/110/111 are never legal, so they report as misaligned too.
    always_comb begin
        misaligned = 1'b1;
        unique case (funct3)
            LB, LBU: misaligned = 1'b0;
            LH, LHU: misaligned = addr[0];
            LW:      misaligned = (addr != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: latches the execute result, runs one data-memory
// access over req/ack, and emits a single-cycle write-back record.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_WIDTH-1:0] ex_alu_out,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_dm_read,
    input  logic                  ex_dm_write,
    input  logic                  ex_reg_write,
    input  logic [4:0]            ex_rd_addr,
    output logic                  dm_req,
    output logic [3:0]            dm_we,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic                  dm_ack,
    input  logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  fwd_valid,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [4:0]            wb_rd_addr,
    output logic [DATA_WIDTH-1:0] wb_rd_data,
    output logic                  misalign_err,
    output logic                  dbg_state
);

    mem_state_t            state;
    logic [DATA_WIDTH-1:0] l_alu;
    logic [2:0]            l_funct3;
    logic                  l_load;
    logic                  l_reg_write;
    logic [4:0]            l_rd;

    logic [2:0]            sel_funct3;
    logic [1:0]            sel_addr;
    logic [3:0]            al_we;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_load;
    logic                  al_mis;
    logic                  is_mem;
    logic                  is_store;
    logic                  op_err;

    // Handshake: an instruction transfers on a rising edge where ex_valid and
    // ex_ready are both 1. ex_ready is a pure decode of the state register, so
    // upstream holds ex_valid and its ex_* fields stable until that edge.
    assign ex_ready  = (state == IDLE);
    assign dbg_state = (state == ACCESS);
    assign fwd_data  = l_alu;

    // One aligner serves both phases: incoming op while idle, latched op while accessing.
    always_comb begin
        sel_funct3 = (state == IDLE) ? ex_funct3 : l_funct3;
        sel_addr   = (state == IDLE) ? ex_alu_out[1:0] : l_alu[1:0];
        is_mem     = ex_dm_read | ex_dm_write;
        is_store   = ex_dm_write;
        op_err     = al_mis | (is_store & ex_funct3[2]);
    end

    load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3     (sel_funct3),
        .addr       (sel_addr),
        .store_data (ex_store_data),
        .rdata      (dm_rdata),
        .we         (al_we),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            l_alu        <= '0;
            l_funct3     <= '0;
            l_load       <= 1'b0;
            l_reg_write  <= 1'b0;
            l_rd         <= '0;
            dm_req       <= 1'b0;
            dm_we        <= '0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            fwd_valid    <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd_addr   <= '0;
            wb_rd_data   <= '0;
            misalign_err <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ex_valid) begin
                        l_alu       <= ex_alu_out;
                        l_funct3    <= ex_funct3;
                        l_load      <= ex_dm_read & ~ex_dm_write;
                        l_reg_write <= ex_reg_write;
                        l_rd        <= ex_rd_addr;
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_reg_write <= ex_reg_write;
                            wb_rd_addr   <= ex_rd_addr;
                            wb_rd_data   <= ex_alu_out;
                        end else if (op_err) begin
                            wb_valid     <= 1'b1;
                            misalign_err <= 1'b1;
                            wb_reg_write <= 1'b0;
                            wb_rd_addr   <= ex_rd_addr;
                            wb_rd_data   <= ex_alu_out;
                        end else begin
                            state     <= ACCESS;
                            dm_req    <= 1'b1;
                            dm_addr   <= ex_alu_out[ADDR_WIDTH+1:2];
                            dm_we     <= is_store ? al_we : 4'b0000;
                            dm_wdata  <= al_wdata;
                            fwd_valid <= is_store;
                        end
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        state        <= IDLE;
                        dm_req       <= 1'b0;
                        fwd_valid    <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= l_load & l_reg_write;
                        wb_rd_addr   <= l_rd;
                        wb_rd_data   <= l_load ? al_load : l_alu;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
